// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared types and constants for the pipelined N-way selector
package proc_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_t;

    // Legal configurations: 2..16 channels, and the select must reach every channel.
    function automatic bit sel_cfg_ok(input int n, input int sel_w);
        return (n >= 2) && (n <= 16) && ((1 << sel_w) >= n);
    endfunction

endpackage

// File: rtl/mux_n_comb.sv
// rtl/mux_n_comb.sv - combinational N-way select with out-of-range flag
module mux_n_comb
    import proc_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   data,
    output logic               err
);

    if (!sel_cfg_ok(N, SEL_W)) begin : g_bad_cfg
        $error("mux_n_comb: illegal N/SEL_W combination");
    end

    // Unmatched selects fall through to zero data with err raised.
    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                data = in_bus[i*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// rtl/mux_n_pipe.sv - N-way selector with registered valid/ready output and 2-entry skid
module mux_n_pipe
    import proc_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_data_err;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;
    logic             skid_valid;
    occ_state_t       state;
    logic             accept;
    logic             consume;

    mux_n_comb #(
        .WIDTH (WIDTH),
        .N     (N),
        .SEL_W (SEL_W)
    ) u_sel (
        .in_bus (in_bus),
        .sel    (sel),
        .data   (sel_data),
        .err    (sel_data_err)
    );

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // in_ready and out_valid are registered decodes of the next occupancy,
    // so neither has a combinational path from out_ready.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_EMPTY;
            out        <= '0;
            sel_err    <= 1'b0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            skid_data  <= '0;
            skid_err   <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out       <= sel_data;
                        sel_err   <= sel_data_err;
                        out_valid <= 1'b1;
                        state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        out     <= sel_data;
                        sel_err <= sel_data_err;
                    end else if (consume) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end else if (accept) begin
                        skid_data  <= sel_data;
                        skid_err   <= sel_data_err;
                        skid_valid <= 1'b1;
                        in_ready   <= 1'b0;
                        state      <= ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        out        <= skid_data;
                        sel_err    <= skid_err;
                        skid_valid <= 1'b0;
                        in_ready   <= 1'b1;
                        state      <= ST_ONE;
                    end
                end
                default: begin
                    out_valid  <= 1'b0;
                    in_ready   <= 1'b1;
                    skid_valid <= 1'b0;
                    state      <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised N-way, WIDTH-bit selector with a registered valid/ready output stage. It is the successor to the datapath 2:1 16-bit mux.
- Used where a selected operand must cross a pipeline boundary under back-pressure, such as writeback-source select or forwarding-source select into the EX stage.
- A 2-entry skid buffer gives full throughput with a registered in_ready.
- Out-of-range selects are flagged rather than silently aliased.

Parameters:
- WIDTH, 16, data width of each channel and of out.
- N, 4, number of input channels (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- in_bus  input  N*WIDTH  channel i occupies in_bus[i*WIDTH +: WIDTH]. Channel 0 is the legacy in_1 and channel 1 is the legacy in_2.
- sel  input  SEL_W  binary channel index, sampled with in_valid.
- in_valid  input  1  upstream offers in_bus/sel this cycle.
- in_ready  output  1  block accepts the offer this cycle; registered.
- out  output  WIDTH  selected data; registered.
- out_valid  output  1  out holds a result.
- out_ready  input  1  downstream consumes out this cycle.
- sel_err  output  1  the item on out was produced from sel >= N; qualified by out_valid.

Behaviour:
- Reset: the block is synchronous, active-low, and sampled on the clk edge. While reset_n=0 at an edge:
  - out=0, out_valid=0, sel_err=0, in_ready=1 after the edge.
  - Both buffer entries are invalidated.
  - Reset mid-transfer discards held items; no partial output.
- Accept: an input is accepted when in_valid && in_ready at the edge. Consume: an output is consumed when out_valid && out_ready at the edge.
- Select function: data = in_bus[sel*WIDTH +: WIDTH] when sel < N. Otherwise data = 0 and err = 1.
- Main register holds {out, sel_err}. The skid register holds {data, err} and has a valid flag.
- State machine (occupancy):
  - EMPTY: out_valid=0, in_ready=1. On accept, go to ONE; the main register loads the selected data. Latency is 1 cycle (out valid on the edge after accept).
  - ONE: out_valid=1, in_ready=1.
    - Accept and consume: stay in ONE; main loads new data.
    - Consume only: go to EMPTY.
    - Accept only: go to TWO; the skid loads new data, main holds.
    - Neither: hold.
  - TWO: out_valid=1, in_ready=0. No accept is possible.
    - Consume: go to ONE; main loads from the skid.
    - Otherwise hold.
- in_ready is a register equal to (next state != TWO), so it has no combinational path from out_ready.
- Ordering: strictly FIFO. Items leave in acceptance order with no drops or duplicates.
- Stability: while out_valid=1 && out_ready=0, out and sel_err must not change.
- in_valid ignored: when in_ready=0, in_bus/sel/in_valid have no effect.
- sel_err is a per-item sideband. It travels with its data through the skid and is not sticky.
- Widths: no arithmetic. Select compare is unsigned on SEL_W bits. For N == 2**SEL_W, sel_err is never set.
- N=2, WIDTH=16 reproduces the legacy mapping: sel=0 selects in_1, sel=1 selects in_2. The only difference is one cycle of latency.

Decomposition:
- Shared package (proc_pkg) holds:
  - DATA_W=16 (default WIDTH).
  - State encoding constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - An elaboration check that 2**SEL_W >= N and 2 <= N <= 16.
- Sub-module mux_n_comb: purely combinational N-way select with the err flag, reusable in unregistered paths.
- mux_n_pipe instantiates mux_n_comb plus the skid/state logic.

Test Plan:
- Reset, then N=4/WIDTH=16 with channels 0..3 = 16'h1111, 16'h2222, 16'h3333, 16'h4444; sel=2, in_valid for 1 cycle, out_ready=1 -> next cycle out=16'h3333, out_valid=1, sel_err=0; following cycle out_valid=0.
- Streaming: sel sequence 0,1,2,3 on consecutive cycles with out_ready=1 -> out = 1111, 2222, 3333, 4444 on consecutive cycles; in_ready stays 1 (full throughput).
- Back-pressure: out_ready=0, offer sel=0 then sel=3 -> after 2 accepts in_ready=0 and out holds 16'h1111 stable. Then out_ready=1 -> 1111 then 4444, in_ready returns to 1 one cycle after the first consume.
- N=3, SEL_W=2, sel=3 -> out=16'h0000, sel_err=1 for that item only; the next item with sel=1 -> sel_err=0.
- Reset mid-operation: reach state TWO, assert reset_n=0 for 1 cycle -> out_valid=0, in_ready=1, out=0, and no stale item ever appears afterwards.
- Legacy equivalence: N=2 instance with random sel/in_bus and out_ready=1 -> out equals a one-cycle-delayed 2:1 mux model for 1000 cycles.
